// File: rtl/led_sequencer.sv
// Run-time selectable LED pattern engine: rotate left/right, bounce and binary
// count, with a 2^speed prescaler divisor, run/pause and output polarity.
module led_sequencer #(
    parameter int NUMBER_OF_LEDS = 6,
    parameter int DELAY_CYCLES   = 13500000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      run,
    input  logic [1:0]                speed,
    output logic [NUMBER_OF_LEDS-1:0] led,
    output logic                      tick
);

    localparam int N  = NUMBER_OF_LEDS;
    localparam int CW = $clog2(DELAY_CYCLES + 1);
    localparam logic [N-1:0] PAT_ONE = N'(1);

    typedef enum logic [1:0] {
        ROTATE_LEFT  = 2'd0,
        ROTATE_RIGHT = 2'd1,
        BOUNCE       = 2'd2,
        BINARY       = 2'd3
    } mode_t;

    logic [N-1:0]  pat;
    logic [N-1:0]  next_pat;
    logic [N-1:0]  start_pat;
    logic [CW-1:0] cnt;
    logic          dir;
    logic          next_dir;
    mode_t         mode_q;
    logic [31:0]   period;
    logic          step_due;

    // A speed shift that would zero the period clamps to one step per cycle.
    always_comb begin
        period = 32'(DELAY_CYCLES) >> speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
    end

    // ">=" rather than "==" so a shortened period mid-count steps immediately.
    assign step_due  = 32'(cnt) >= (period - 32'd1);
    assign start_pat = (mode_t'(mode) == BINARY) ? '0 : PAT_ONE;

    always_comb begin
        next_pat = pat;
        next_dir = dir;
        case (mode_q)
            ROTATE_LEFT:  next_pat = {pat[N-2:0], pat[N-1]};
            ROTATE_RIGHT: next_pat = {pat[0], pat[N-1:1]};
            BOUNCE: begin
                // Direction flips in the same update that lands on an endpoint,
                // so each endpoint is lit for exactly one step per sweep.
                if (dir) begin
                    next_pat = pat << 1;
                    next_dir = ~pat[N-2];
                end else begin
                    next_pat = pat >> 1;
                    next_dir = pat[1];
                end
            end
            BINARY:       next_pat = pat + PAT_ONE;
            default:      next_pat = pat;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (mode_t'(mode) != mode_q)) begin
            mode_q <= mode_t'(mode);
            pat    <= start_pat;
            cnt    <= '0;
            dir    <= 1'b1;
            tick   <= 1'b0;
        end else if (run) begin
            if (step_due) begin
                cnt  <= '0;
                pat  <= next_pat;
                dir  <= next_dir;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign led = ACTIVE_LOW ? ~pat : pat;

endmodule
